multicycle_ctrl: RTL and testbench

- Multi-cycle control unit. It drives the datapath control inputs (reg_write, mem2reg, alu_src, mem_write, mem_read, alu_cc) from the opcode/funct7/funct3 fields the datapath presents.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It adds PC and IR write enables, a memory-ready handshake, an illegal-instruction trap and a retired-instruction counter.
- Sits beside the datapath in the top level, one instance per core.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// latches the instruction class and ALU code in DECODE, traps on illegal encodings
// and counts retired instructions.
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | load IR from instruction memory
// DECODE | classify opcode/funct fields, latch class and alu_cc
// EXEC   | ALU operation on latched alu_cc
// MEM    | data memory access, held until mem_ready
// WB     | register file write, PC update, retire
// TRAP   | illegal instruction seen; parked until reset
module multicycle_ctrl #(
  parameter int ALU_CC_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  input  logic [2:0]          funct3,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_write,
  output logic                mem_read,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_R     = 2'd0,
    CLS_I     = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } cls_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(4'b0000);
  localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(4'b0001);
  localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(4'b0010);
  localparam logic [ALU_CC_W-1:0] CC_XOR = ALU_CC_W'(4'b0011);
  localparam logic [ALU_CC_W-1:0] CC_SLL = ALU_CC_W'(4'b0100);
  localparam logic [ALU_CC_W-1:0] CC_SRL = ALU_CC_W'(4'b0101);
  localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(4'b0110);
  localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(4'b0111);
  localparam logic [ALU_CC_W-1:0] CC_SRA = ALU_CC_W'(4'b1000);

  state_t                state_q, state_d;
  cls_t                  cls_q, dec_cls;
  logic [ALU_CC_W-1:0]   cc_q, dec_cc;
  logic                  dec_ok;
  logic                  illegal_q;
  logic [CNT_W-1:0]      retired_q;
  logic                  retire;

  // Instruction decode; only consumed while in DECODE, never drives outputs directly.
  always_comb begin
    dec_cls = CLS_R;
    dec_cc  = CC_ADD;
    dec_ok  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_cls = CLS_R;
        dec_ok  = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        case (funct3)
          3'b000:  dec_cc = (funct7 == F7_ALT) ? CC_SUB : CC_ADD;
          3'b001:  dec_cc = CC_SLL;
          3'b100:  dec_cc = CC_XOR;
          3'b101:  dec_cc = (funct7 == F7_ALT) ? CC_SRA : CC_SRL;
          3'b110:  dec_cc = CC_OR;
          3'b111:  dec_cc = CC_AND;
          default: dec_ok = 1'b0;
        endcase
      end
      OP_I: begin
        dec_cls = CLS_I;
        dec_ok  = 1'b1;
        case (funct3)
          3'b000:  dec_cc = CC_ADD;
          3'b001:  dec_cc = CC_SLL;
          3'b010:  dec_cc = CC_SLT;
          3'b100:  dec_cc = CC_XOR;
          3'b101:  dec_cc = (funct7 == F7_ALT) ? CC_SRA : CC_SRL;
          3'b110:  dec_cc = CC_OR;
          3'b111:  dec_cc = CC_AND;
          default: dec_ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec_cls = CLS_LOAD;
        dec_ok  = (funct3 == 3'b010);
      end
      OP_STORE: begin
        dec_cls = CLS_STORE;
        dec_ok  = (funct3 == 3'b010);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // State register plus the fields latched in DECODE, trap flag and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_R;
      cc_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        cc_q  <= dec_cc;
        if (!dec_ok) illegal_q <= 1'b1;
      end
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  // Next state and control strobes, decoded from the state register and latched fields.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    alu_src   = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    alu_cc    = '0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: state_d = dec_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_cc  = cc_q;
        alu_src = (cls_q != CLS_R);
        state_d = ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_cc    = CC_ADD;
        alu_src   = 1'b1;
        mem_read  = (cls_q == CLS_LOAD);
        mem_write = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_cc    = cc_q;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        mem2reg   = (cls_q == CLS_LOAD);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Reset is asynchronous, so strobes must drop the moment it asserts (e.g. mid-MEM).
    if (!reset) begin
      retire    = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem2reg   = 1'b0;
      alu_src   = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      alu_cc    = '0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: expected per-cycle output records are queued when an
// instruction is issued and compared cycle by cycle as the controller steps.
// A second instance with a 4-bit counter exercises counter wraparound.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_ready = 1'b0;

  logic        pc_write, ir_write, reg_write, mem2reg, alu_src, mem_write, mem_read, illegal;
  logic [3:0]  alu_cc;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        pc_write_w, ir_write_w, reg_write_w, mem2reg_w, alu_src_w, mem_write_w, mem_read_w, illegal_w;
  logic [3:0]  alu_cc_w;
  logic [2:0]  state_w;
  logic [3:0]  retired_w;

  multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem2reg(mem2reg), .alu_src(alu_src), .mem_write(mem_write), .mem_read(mem_read),
    .alu_cc(alu_cc), .state(state), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .mem_ready(mem_ready), .pc_write(pc_write_w), .ir_write(ir_write_w), .reg_write(reg_write_w),
    .mem2reg(mem2reg_w), .alu_src(alu_src_w), .mem_write(mem_write_w), .mem_read(mem_read_w),
    .alu_cc(alu_cc_w), .state(state_w), .illegal(illegal_w), .retired(retired_w)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011;
  localparam logic [3:0] C_SLL = 4'b0100, C_SRL = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111;
  localparam logic [3:0] C_SRA = 4'b1000;
  localparam logic [6:0] OR_ = 7'b0110011, OI = 7'b0010011, OL = 7'b0000011, OS = 7'b0100011;
  localparam logic [6:0] FZ = 7'b0000000, FA = 7'b0100000;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_ILL = 4;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    int         cls;
    logic [3:0] cc;
    int         nw;
  } instr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_ret  = 0;
  logic [31:0] exp_q[$];
  logic        mr_q[$];

  function automatic logic [31:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                     input logic rw, input logic m2r, input logic asrc,
                                     input logic mw, input logic mr, input logic [3:0] cc,
                                     input logic ill, input logic [15:0] ret);
    return {1'b0, st, pcw, irw, rw, m2r, asrc, mw, mr, cc, ill, ret};
  endfunction

  function automatic logic [31:0] obs();
    return {1'b0, state, pc_write, ir_write, reg_write, mem2reg, alu_src, mem_write, mem_read,
            alu_cc, illegal, retired};
  endfunction

  function automatic logic [31:0] obs_w();
    return {1'b0, state_w, pc_write_w, ir_write_w, reg_write_w, mem2reg_w, alu_src_w, mem_write_w,
            mem_read_w, alu_cc_w, illegal_w, 12'h000, retired_w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] rec, input logic mr);
    exp_q.push_back(rec);
    mr_q.push_back(mr);
  endtask

  // Called at a falling edge: apply this cycle's mem_ready, compare, move to next falling edge.
  task automatic step(input string tag);
    logic [31:0] rec;
    mem_ready = mr_q.pop_front();
    rec = exp_q.pop_front();
    #1;
    chk(tag, obs(), rec);
    chk({tag, "_w"}, obs_w(), {rec[31:16], 12'h000, rec[3:0]});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_assert", obs(), 32'h0);
    @(negedge clk);
    chk("rst_held", obs(), 32'h0);
    reset = 1'b1;
    exp_ret = 0;
  endtask

  task automatic run_instr(input instr_t t);
    logic [15:0] r;
    int k;
    r = exp_ret[15:0];
    opcode = t.op;
    funct7 = t.f7;
    funct3 = t.f3;
    push(mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, r), 1'b1);
    push(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, r), 1'b1);
    if (t.cls == K_ILL) begin
      for (int i = 0; i < 11; i++)
        push(mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, r), 1'b1);
    end else begin
      push(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, t.cls != K_R, 1'b0, 1'b0, t.cc, 1'b0, r), 1'b1);
      if (t.cls == K_R || t.cls == K_I) begin
        push(mk(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t.cc, 1'b0, r), 1'b1);
      end else if (t.cls == K_LD) begin
        for (int i = 0; i < t.nw; i++)
          push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_ADD, 1'b0, r), 1'b0);
        push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_ADD, 1'b0, r), 1'b1);
        push(mk(3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_ADD, 1'b0, r), 1'b1);
      end else begin
        for (int i = 0; i < t.nw; i++)
          push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ADD, 1'b0, r), 1'b0);
        push(mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_ADD, 1'b0, r), 1'b1);
      end
      exp_ret++;
    end
    k = 0;
    while (exp_q.size() > 0) begin
      step(t.name);
      k++;
      // Fields are latched by now; garbage on the inputs must not disturb outputs.
      if (k == 2) begin
        opcode = 7'h7f;
        funct7 = 7'h7f;
        funct3 = 3'b011;
      end
    end
  endtask

  instr_t legal_tbl [20] = '{
    '{"add",  OR_, FZ, 3'b000, K_R,  C_ADD, 0},
    '{"sub",  OR_, FA, 3'b000, K_R,  C_SUB, 0},
    '{"addi", OI,  7'h15, 3'b000, K_I, C_ADD, 0},
    '{"lw3",  OL,  FZ, 3'b010, K_LD, C_ADD, 3},
    '{"sw",   OS,  FZ, 3'b010, K_ST, C_ADD, 0},
    '{"sll",  OR_, FZ, 3'b001, K_R,  C_SLL, 0},
    '{"xor",  OR_, FZ, 3'b100, K_R,  C_XOR, 0},
    '{"srl",  OR_, FZ, 3'b101, K_R,  C_SRL, 0},
    '{"sra",  OR_, FA, 3'b101, K_R,  C_SRA, 0},
    '{"or",   OR_, FZ, 3'b110, K_R,  C_OR,  0},
    '{"and",  OR_, FZ, 3'b111, K_R,  C_AND, 0},
    '{"slti", OI,  FZ, 3'b010, K_I,  C_SLT, 0},
    '{"xori", OI,  7'h33, 3'b100, K_I, C_XOR, 0},
    '{"ori",  OI,  FZ, 3'b110, K_I,  C_OR,  0},
    '{"andi", OI,  FA, 3'b111, K_I,  C_AND, 0},
    '{"slli", OI,  FZ, 3'b001, K_I,  C_SLL, 0},
    '{"srli", OI,  FZ, 3'b101, K_I,  C_SRL, 0},
    '{"srai", OI,  FA, 3'b101, K_I,  C_SRA, 0},
    '{"sw2",  OS,  FZ, 3'b010, K_ST, C_ADD, 2},
    '{"lw0",  OL,  FZ, 3'b010, K_LD, C_ADD, 0}
  };

  instr_t ill_tbl [6] = '{
    '{"ill_op",   7'h7f, FZ, 3'b000, K_ILL, 4'h0, 0},
    '{"ill_r_f7", OR_, 7'b0000001, 3'b000, K_ILL, 4'h0, 0},
    '{"ill_r_f3", OR_, FZ, 3'b010, K_ILL, 4'h0, 0},
    '{"ill_i_f3", OI,  FZ, 3'b011, K_ILL, 4'h0, 0},
    '{"ill_ld",   OL,  FZ, 3'b000, K_ILL, 4'h0, 0},
    '{"ill_st",   OS,  FZ, 3'b001, K_ILL, 4'h0, 0}
  };

  initial begin
    @(negedge clk);
    do_reset();

    foreach (legal_tbl[i]) run_instr(legal_tbl[i]);
    chk("retired_total", 32'(retired), 32'd20);
    chk("retired_wrap4", 32'(retired_w), 32'd4);

    foreach (ill_tbl[i]) begin
      run_instr(ill_tbl[i]);
      do_reset();
    end

    // Reset in the middle of a load access: strobes drop at once, access not counted.
    run_instr('{"addi_pre", OI, FZ, 3'b000, K_I, C_ADD, 0});
    opcode = OL;
    funct7 = FZ;
    funct3 = 3'b010;
    push(mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'd1), 1'b1);
    push(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'd1), 1'b1);
    push(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_ADD, 1'b0, 16'd1), 1'b1);
    push(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_ADD, 1'b0, 16'd1), 1'b0);
    while (exp_q.size() > 0) step("lw_abort");
    mem_ready = 1'b0;
    #1;
    chk("abort_pre_mem_read", 32'(mem_read), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_outs", obs(), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_ret = 0;
    run_instr('{"addi_post", OI, FZ, 3'b000, K_I, C_ADD, 0});
    chk("retired_post_abort", 32'(retired), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
